// File: rtl/alu_pkg.sv
// Shared types and constants for the alu_unit execute slice.
package alu_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'b0000,
      ALU_SUB    = 4'b0001,
      ALU_AND    = 4'b0010,
      ALU_OR     = 4'b0011,
      ALU_XOR    = 4'b0100,
      ALU_SLT    = 4'b0101,
      ALU_SLTU   = 4'b0110,
      ALU_SLL    = 4'b0111,
      ALU_SRL    = 4'b1000,
      ALU_SRA    = 4'b1001,
      ALU_MUL    = 4'b1010,
      ALU_MULH   = 4'b1011,
      ALU_MULHSU = 4'b1100,
      ALU_MULHU  = 4'b1101,
      ALU_DIV    = 4'b1110,
      ALU_REM    = 4'b1111
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state_t;

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per cycle,
// XLEN cycles after start. Sign handling is left to the caller.
module alu_divider
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            busy,
   output logic [XLEN-1:0] quot,
   output logic [XLEN-1:0] rem
);

   localparam int CW = $clog2(XLEN) + 1;

   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] q, r, d, diff;
   logic [XLEN:0]   shifted;
   logic            ge;

   // Partial remainder shifted left by one with the next dividend bit.
   assign shifted = {r, q[XLEN-1]};
   assign ge      = (shifted >= {1'b0, d});
   assign diff    = shifted[XLEN-1:0] - d;
   assign busy    = (cnt != '0);
   assign quot    = q;
   assign rem     = r;

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (start)
         cnt <= CW'(XLEN);
      else if (busy)
         cnt <= cnt - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (start) begin
         q <= dividend;
         r <= '0;
         d <= divisor;
      end else if (busy) begin
         q <= {q[XLEN-2:0], ge};
         r <= ge ? diff : shifted[XLEN-1:0];
      end
   end

endmodule

// File: rtl/alu_unit.sv
// Handshaked RV32I execute unit: ALUOp/funct decode, single-cycle ALU, registered result.
// Define RV_M_EN to build the M-extension (single-cycle multiply, iterative divide).
module alu_unit
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      ALUOp,
   input  logic            opb5,
   input  logic [2:0]      funct3,
   input  logic            funct7b5,
   input  logic            funct7b0,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   localparam int SW = $clog2(XLEN);
   localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

   alu_state_t      state;
   alu_ctrl_t       ctrl;
   logic            is_m, accept, acc_long, acc_illegal;
   logic [XLEN-1:0] acc_result;
   logic [SW-1:0]   shamt;

   assign is_m      = opb5 & funct7b0 & ALUOp[1];
   assign shamt     = src_b[SW-1:0];
   assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign out_valid = (state == DONE);
   assign zero      = (result == '0);

   always_comb begin
      ctrl = ALU_ADD;
      if (ALUOp == ALUOP_SUB) begin
         ctrl = ALU_SUB;
      end else if (is_m) begin
         case (funct3)
            3'b000:         ctrl = ALU_MUL;
            3'b001:         ctrl = ALU_MULH;
            3'b010:         ctrl = ALU_MULHSU;
            3'b011:         ctrl = ALU_MULHU;
            3'b100, 3'b101: ctrl = ALU_DIV;
            default:        ctrl = ALU_REM;
         endcase
      end else if (ALUOp[1]) begin
         case (funct3)
            3'b000:  ctrl = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  ctrl = ALU_SLL;
            3'b010:  ctrl = ALU_SLT;
            3'b011:  ctrl = ALU_SLTU;
            3'b100:  ctrl = ALU_XOR;
            3'b101:  ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  ctrl = ALU_OR;
            default: ctrl = ALU_AND;
         endcase
      end
   end

`ifdef RV_M_EN
   logic [2*XLEN-1:0] ext_a, ext_b, prod;
   logic [XLEN-1:0]   mag_a, mag_b, div_q, div_r, q_fix, r_fix;
   logic              div_uns, a_neg, b_neg, div_zero, div_ovf;
   logic              div_busy, neg_q, neg_r, sel_rem;

   // DIVU/REMU are the odd funct3 codes of the divide group.
   assign div_uns = funct3[0];

   // One 2*XLEN product; operand extension picks the signedness of the high half.
   assign ext_a = (ctrl == ALU_MULH || ctrl == ALU_MULHSU) ?
                  {{XLEN{src_a[XLEN-1]}}, src_a} : {{XLEN{1'b0}}, src_a};
   assign ext_b = (ctrl == ALU_MULH) ?
                  {{XLEN{src_b[XLEN-1]}}, src_b} : {{XLEN{1'b0}}, src_b};
   assign prod  = ext_a * ext_b;

   assign a_neg    = ~div_uns & src_a[XLEN-1];
   assign b_neg    = ~div_uns & src_b[XLEN-1];
   assign mag_a    = a_neg ? ('0 - src_a) : src_a;
   assign mag_b    = b_neg ? ('0 - src_b) : src_b;
   assign div_zero = (src_b == '0);
   assign div_ovf  = ~div_uns & (src_a == SMIN) & (src_b == '1);

   // Divide-by-zero and MIN/-1 finish in one cycle through the ALU path.
   assign acc_long    = (ctrl == ALU_DIV || ctrl == ALU_REM) & ~div_zero & ~div_ovf;
   assign acc_illegal = 1'b0;

   always_ff @(posedge clk) begin
      if (accept) begin
         neg_q   <= a_neg ^ b_neg;
         neg_r   <= a_neg;
         sel_rem <= (ctrl == ALU_REM);
      end
   end

   alu_divider #(.XLEN(XLEN)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (accept & acc_long),
      .dividend (mag_a),
      .divisor  (mag_b),
      .busy     (div_busy),
      .quot     (div_q),
      .rem      (div_r)
   );

   assign q_fix = neg_q ? ('0 - div_q) : div_q;
   assign r_fix = neg_r ? ('0 - div_r) : div_r;
`else
   assign acc_long    = 1'b0;
   assign acc_illegal = is_m;
`endif

   always_comb begin
      acc_result = '0;
      case (ctrl)
         ALU_ADD:    acc_result = src_a + src_b;
         ALU_SUB:    acc_result = src_a - src_b;
         ALU_AND:    acc_result = src_a & src_b;
         ALU_OR:     acc_result = src_a | src_b;
         ALU_XOR:    acc_result = src_a ^ src_b;
         ALU_SLT:    acc_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         ALU_SLTU:   acc_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
         ALU_SLL:    acc_result = src_a << shamt;
         ALU_SRL:    acc_result = src_a >> shamt;
         ALU_SRA:    acc_result = $signed(src_a) >>> shamt;
`ifdef RV_M_EN
         ALU_MUL:    acc_result = prod[XLEN-1:0];
         ALU_MULH,
         ALU_MULHSU,
         ALU_MULHU:  acc_result = prod[2*XLEN-1:XLEN];
         ALU_DIV:    acc_result = div_zero ? '1 : SMIN;
         ALU_REM:    acc_result = div_zero ? src_a : '0;
`endif
         default:    acc_result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         result  <= '0;
         illegal <= 1'b0;
      end else begin
`ifdef RV_M_EN
         if (state == BUSY) begin
            if (!div_busy) begin
               state   <= DONE;
               result  <= sel_rem ? r_fix : q_fix;
               illegal <= 1'b0;
            end
         end else
`endif
         if (accept) begin
            if (acc_long) begin
               state <= BUSY;
            end else begin
               state   <= DONE;
               result  <= acc_result;
               illegal <= acc_illegal;
            end
         end else if (state != DONE || out_ready) begin
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed cases plus randomized traffic against a
// behavioural model and a cycle-level handshake scoreboard.
module tb_alu_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [1:0]   ALUOp = 2'b00;
   logic         opb5 = 1'b0;
   logic [2:0]   funct3 = 3'b000;
   logic         funct7b5 = 1'b0;
   logic         funct7b0 = 1'b0;
   logic [W-1:0] src_a = '0;
   logic [W-1:0] src_b = '0;
   logic         in_ready, out_valid, zero, illegal;
   logic [W-1:0] result;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_unit #(.XLEN(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ALUOp     (ALUOp),
      .opb5      (opb5),
      .funct3    (funct3),
      .funct7b5  (funct7b5),
      .funct7b0  (funct7b0),
      .src_a     (src_a),
      .src_b     (src_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   function automatic void check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // Architectural meaning of each encoding, from the instruction-set rules.
   function automatic void ref_model(input logic [1:0] op, input logic o5, input logic [2:0] f3,
                                     input logic f75, input logic f70,
                                     input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] r, output logic ill, output int lat);
      longint sa, sb, t;
      ill = 1'b0;
      lat = 1;
      r   = '0;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      t   = 0;
      if (op == 2'b00) r = a + b;
      else if (op == 2'b01) r = a - b;
      else if (o5 && f70) begin
`ifdef RV_M_EN
         case (f3)
            3'd0: begin t = sa * sb; r = t[31:0]; end
            3'd1: begin t = sa * sb; r = t[63:32]; end
            3'd2: begin t = sa * longint'({32'b0, b}); r = t[63:32]; end
            3'd3: begin
               logic [63:0] pu;
               pu = {32'b0, a} * {32'b0, b};
               r  = pu[63:32];
            end
            default: begin
               if (b == 0) r = f3[1] ? a : 32'hFFFF_FFFF;
               else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                  r = f3[1] ? 32'h0 : 32'h8000_0000;
               else begin
                  lat = W + 1;
                  if (f3[0]) r = f3[1] ? a % b : a / b;
                  else begin
                     t = f3[1] ? sa % sb : sa / sb;
                     r = t[31:0];
                  end
               end
            end
         endcase
`else
         ill = 1'b1;
         r   = '0;
`endif
      end else begin
         case (f3)
            3'd0: r = (o5 && f75) ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
               if (f75) begin
                  t = sa >>> b[4:0];
                  r = t[31:0];
               end else r = a >> b[4:0];
            end
            3'd6: r = a | b;
            default: r = a & b;
         endcase
      end
   endfunction

   typedef struct {
      logic [W-1:0] res;
      logic         ill;
      int           due;
   } exp_t;

   exp_t         sb_q[$];
   logic [W-1:0] last_res = '0;

   // Cycle-level scoreboard: at most one op in flight, visible from its due cycle on.
   always @(negedge clk) begin
      logic         done_e, busy_e, rdy_e, mill;
      logic [W-1:0] exp_res, mres;
      int           mlat;
      if (!rst_n) begin
         sb_q.delete();
         last_res = '0;
      end else begin
         done_e  = (sb_q.size() > 0) && (cyc >= sb_q[0].due);
         busy_e  = (sb_q.size() > 0) && !done_e;
         rdy_e   = !busy_e && (!done_e || out_ready);
         exp_res = done_e ? sb_q[0].res : last_res;
         check("mon_out_valid", W'(out_valid), W'(done_e));
         check("mon_in_ready", W'(in_ready), W'(rdy_e));
         check("mon_result", result, exp_res);
         check("mon_zero", W'(zero), W'(exp_res == '0));
         if (done_e) check("mon_illegal", W'(illegal), W'(sb_q[0].ill));
         if (done_e && out_ready) begin
            last_res = sb_q[0].res;
            void'(sb_q.pop_front());
         end
         if (in_valid && rdy_e) begin
            ref_model(ALUOp, opb5, funct3, funct7b5, funct7b0, src_a, src_b, mres, mill, mlat);
            sb_q.push_back('{res: mres, ill: mill, due: cyc + mlat});
         end
      end
   end

   task automatic drive_op(input logic [1:0] op, input logic o5, input logic [2:0] f3,
                           input logic f75, input logic f70,
                           input logic [W-1:0] a, input logic [W-1:0] b);
      ALUOp    = op;
      opb5     = o5;
      funct3   = f3;
      funct7b5 = f75;
      funct7b0 = f70;
      src_a    = a;
      src_b    = b;
   endtask

   task automatic do_op(input string nm, input logic [1:0] op, input logic o5, input logic [2:0] f3,
                        input logic f75, input logic f70,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_r, input logic exp_ill, input int exp_lat);
      int lat;
      bit got;
      @(posedge clk); #1;
      drive_op(op, o5, f3, f75, f70, a, b);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check({nm, "_in_ready"}, W'(in_ready), W'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      src_a    = $urandom();
      src_b    = $urandom();
      funct3   = 3'($urandom_range(0, 7));
      lat = 0;
      got = 1'b0;
      while (!got && lat < 80) begin
         @(negedge clk);
         lat++;
         if (out_valid === 1'b1) got = 1'b1;
      end
      if (!got) check({nm, "_timeout"}, W'(0), W'(1));
      else begin
         check({nm, "_result"}, result, exp_r);
         check({nm, "_illegal"}, W'(illegal), W'(exp_ill));
         check({nm, "_zero"}, W'(zero), W'(exp_r == '0));
         check({nm, "_latency"}, W'(lat), W'(exp_lat));
      end
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'd1;
         4:       return 32'($urandom_range(0, 40));
         default: return $urandom();
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required $finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] mr;
      logic         mi;
      int           ml;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_result", result, W'(0));
      check("rst_zero", W'(zero), W'(1));
      check("rst_illegal", W'(illegal), W'(0));
      check("rst_in_ready", W'(in_ready), W'(1));

      ref_model(2'b10, 1'b1, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, mr, mi, ml);
      check("pin_sub", mr, 32'hFFFF_FFFE);
      ref_model(2'b10, 1'b0, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'h24, mr, mi, ml);
      check("pin_sra", mr, 32'hF800_0000);
      ref_model(2'b10, 1'b1, 3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, mr, mi, ml);
      check("pin_slt", mr, 32'd1);
`ifdef RV_M_EN
      ref_model(2'b10, 1'b1, 3'b100, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, mr, mi, ml);
      check("pin_div", mr, 32'hFFFF_FFFD);
      check("pin_div_lat", W'(ml), W'(W + 1));
`endif

      do_op("sub_r",   2'b10, 1'b1, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
      do_op("addi",    2'b10, 1'b0, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0, 1);
      do_op("sra",     2'b10, 1'b1, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, 1);
      do_op("srl",     2'b10, 1'b1, 3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0, 1);
      do_op("aluop01", 2'b01, 1'b0, 3'b111, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 1'b0, 1);
      do_op("sltu",    2'b10, 1'b1, 3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
`ifdef RV_M_EN
      do_op("div_neg", 2'b10, 1'b1, 3'b100, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, W + 1);
      do_op("rem_neg", 2'b10, 1'b1, 3'b110, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, W + 1);
      do_op("divu_z",  2'b10, 1'b1, 3'b101, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
      do_op("div_ovf", 2'b10, 1'b1, 3'b100, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
      do_op("rem_ovf", 2'b10, 1'b1, 3'b110, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
      do_op("mul",     2'b10, 1'b1, 3'b000, 1'b0, 1'b1, 32'd6, 32'd7, 32'd42, 1'b0, 1);
`else
      do_op("mul_ill", 2'b10, 1'b1, 3'b000, 1'b0, 1'b1, 32'd6, 32'd7, 32'd0, 1'b1, 1);
`endif

      // Backpressure: op1 held while op2 waits, then all three drain in order.
      @(posedge clk); #1;
      drive_op(2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      drive_op(2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'd10, 32'd20);
      repeat (3) begin
         @(negedge clk);
         check("bp_hold_result", result, 32'd3);
         check("bp_hold_valid", W'(out_valid), W'(1));
         check("bp_hold_in_ready", W'(in_ready), W'(0));
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_rel_result1", result, 32'd3);
      check("bp_rel_in_ready", W'(in_ready), W'(1));
      @(posedge clk); #1;
      drive_op(2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'd100, 32'd200);
      @(negedge clk);
      check("bp_result2", result, 32'd30);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_result3", result, 32'd300);
      check("bp_valid3", W'(out_valid), W'(1));
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_drained", W'(out_valid), W'(0));
      check("bp_hold_last", result, 32'd300);

      // Reset while an op is outstanding.
      @(posedge clk); #1;
`ifdef RV_M_EN
      drive_op(2'b10, 1'b1, 3'b100, 1'b0, 1'b1, 32'd100, 32'd7);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
`else
      drive_op(2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'd5, 32'd6);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
`endif
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rstmid_out_valid", W'(out_valid), W'(0));
      check("rstmid_result", result, W'(0));
      check("rstmid_zero", W'(zero), W'(1));
      check("rstmid_in_ready", W'(in_ready), W'(1));

      // Randomized traffic, checked by the scoreboard.
      for (int i = 0; i < 700; i++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         drive_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), pick(), pick());
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (W + 8) @(posedge clk);
      @(negedge clk);
      check("final_drained", W'(sb_q.size()), W'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
